reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Tracks destination registers with results still in flight from long-latency producers (loads, multi-cycle MUL/DIV). It sits in the ID stage and produces the stall that the EX-side bypass network cannot resolve. Long-latency writebacks retire pending entries and release stalls. This block is the issue-side counterpart to the EX-stage operand bypass logic.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum simultaneously pending long-latency writes, range 1..15.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `id_valid`, input, 1: ID stage holds a valid instruction.
- `id_rs1`, input, 5: source register 1 index.
- `id_rs2`, input, 5: source register 2 index.
- `id_use_rs1`, input, 1: the instruction reads rs1.
- `id_use_rs2`, input, 1: the instruction reads rs2.
- `id_rd`, input, 5: destination register index.
- `id_reg_write`, input, 1: the instruction writes rd.
- `id_long`, input, 1: rd is produced by a long-latency unit.
- `id_flush`, input, 1: ID instruction is squashed this cycle.
- `wb_valid`, input, 1: long-latency result written back this cycle.
- `wb_rd`, input, 5: writeback destination index.
- `stall`, output, 1: hold IF/ID and bubble ID/EX. Combinational.
- `busy`, output, 32: pending bitmap, bit i = register i pending. Registered.
- `outstanding`, output, 4: count of pending long-latency writes. Registered.
- `idle`, output, 1: `outstanding == 0`. Registered.
- `err`, output, 1: sticky protocol-error flag. Registered.

## Operation
- Bit 0 of `busy` is hardwired 0. An `id_rd` of 0 never sets a bit.
- An issue is accepted when `id_valid && !id_flush && !stall`.
- A long issue is an accepted issue with `id_reg_write && id_long && id_rd != 0`. It sets `busy[id_rd]` and increments `outstanding`.
- A retire is `wb_valid && wb_rd != 0 && busy[wb_rd]`. It clears `busy[wb_rd]` and decrements `outstanding`.
- `wb_valid` with `wb_rd == 0`, or with `busy[wb_rd] == 0`, sets `err`. Such a writeback changes neither state nor count.
- Effective pending is computed per register: eff[i] = `busy[i]` AND NOT (retire of register i this cycle). A same-cycle writeback therefore releases the stall, because the regfile is write-through.
- `stall = id_valid && !id_flush && (RAW || WAW || FULL)`, where:
  - RAW: (`id_use_rs1` and eff[`id_rs1`]) or (`id_use_rs2` and eff[`id_rs2`]).
  - WAW: `id_reg_write` and eff[`id_rd`].
  - FULL: `id_long` and `id_reg_write` and `outstanding == MAX_OUTSTANDING` and no retire this cycle.
- Retire and long issue on the same register in the same cycle: the issue's set takes priority, so the bit stays 1.
- Counter update:
  - +1 on a long issue only.
  - −1 on a retire only.
  - Unchanged when both happen in the same cycle.
  - The counter never wraps. A decrement at 0 cannot occur, because a retire requires a busy bit.
- `id_flush` suppresses the stall and blocks issue. It does not clear pending entries, because already-issued long ops always write back.
- `err` clears only on reset.

## Timing
- Reset, asynchronous, while `rst_n` is low: `busy = 0`, `outstanding = 0`, `idle = 1`, `err = 0`. `stall` then follows its equation with all bits clear.
- `stall` has zero latency: it is combinational from the ID inputs, `wb_*`, and registered state.
- Set latency: a bit set by a long issue at edge N is visible from cycle N+1.
- A dependent instruction in ID at cycle N+1 stalls until the cycle in which the matching `wb_valid` arrives. It issues in that cycle.
- `idle` and `outstanding` update on the same edge as `busy`.
- Reset asserted mid-operation drops all pending state immediately. Writebacks that arrive after reset set `err`; upstream must also reset the long units.

## Test plan
- Load-use RAW:
  - Stimulus: long issue rd=5 at cycle 0. Next instruction reads rs1=5. `wb_valid`, `wb_rd=5` at cycle 4.
  - Required: `stall=1` in cycles 1–3, `stall=0` in cycle 4, `busy[5]=0` and `outstanding=0` from cycle 5.
- WAW plus priority:
  - Stimulus: pending rd=7. New long issue rd=7 in the same cycle as the writeback of r7.
  - Required: no stall, `busy[7]` remains 1, `outstanding` unchanged at 1.
- Full:
  - Stimulus: with `MAX_OUTSTANDING=4`, long issues to r1–r4, then a 5th long issue to r9.
  - Required: `stall=1` for the 5th issue. With a writeback of r1 in the same cycle, `stall=0` and `outstanding` stays 4.
- x0 and unused sources:
  - Stimulus 1: long issue with rd=0.
  - Required: `busy` unchanged, `outstanding` unchanged.
  - Stimulus 2: rs2=5 pending with `id_use_rs2=0`.
  - Required: `stall=0`.
- Flush and error:
  - Stimulus 1: `id_flush=1` with a RAW-hazard instruction.
  - Required: `stall=0` and no state change.
  - Stimulus 2: `wb_valid` with `wb_rd=12` while r12 is idle.
  - Required: `err=1` from the next cycle, held until `rst_n` is low.
- Async reset mid-operation:
  - Stimulus: drop `rst_n` between clock edges with 3 writes pending.
  - Required: `busy=0`, `outstanding=0`, `idle=1` immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: tracks destination registers with
// long-latency results in flight and raises the ID-stage stall for RAW, WAW
// and capacity hazards that the EX bypass network cannot resolve.
module reg_scoreboard #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_long,
    input  logic        id_flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic        stall,
    output logic [31:0] busy,
    output logic [3:0]  outstanding,
    output logic        idle,
    output logic        err
);

    localparam logic [3:0] MaxCnt = 4'(MAX_OUTSTANDING);

    logic [31:0] busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        idle_q, idle_d;
    logic        err_q, err_d;

    logic        retire;
    logic [31:0] ret_vec;
    logic [31:0] eff;
    logic        raw, waw, full;
    logic        long_issue;
    logic [31:0] set_vec;

    // Hazard detection: a same-cycle retire hides its busy bit (write-through regfile)
    always_comb begin
        ret_vec = '0;
        retire  = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
        if (retire) begin
            ret_vec[wb_rd] = 1'b1;
        end
        eff   = busy_q & ~ret_vec;
        raw   = (id_use_rs1 && eff[id_rs1]) || (id_use_rs2 && eff[id_rs2]);
        waw   = id_reg_write && eff[id_rd];
        full  = id_long && id_reg_write && (cnt_q == MaxCnt) && !retire;
        stall = id_valid && !id_flush && (raw || waw || full);
    end

    // Next state: set after clear so a same-register issue wins over its retire
    always_comb begin
        set_vec    = '0;
        long_issue = id_valid && !id_flush && !stall &&
                     id_reg_write && id_long && (id_rd != 5'd0);
        if (long_issue) begin
            set_vec[id_rd] = 1'b1;
        end
        busy_d    = (busy_q & ~ret_vec) | set_vec;
        busy_d[0] = 1'b0;
        cnt_d     = cnt_q;
        if (long_issue && !retire) begin
            cnt_d = cnt_q + 4'd1;
        end else if (retire && !long_issue) begin
            cnt_d = cnt_q - 4'd1;
        end
        idle_d = (cnt_d == 4'd0);
        err_d  = err_q | (wb_valid && !retire);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
            idle_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            idle_q <= idle_d;
            err_q  <= err_d;
        end
    end

    assign busy        = busy_q;
    assign outstanding = cnt_q;
    assign idle        = idle_q;
    assign err         = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios plus randomized traffic,
// compared against a pending-set model of the scoreboard rules.
module tb_reg_scoreboard;

    localparam int unsigned MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_long, id_flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic [31:0] busy;
    logic [3:0]  outstanding;
    logic        idle;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Model: set of pending registers plus sticky error
    bit pend[32];
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard #(.MAX_OUTSTANDING(MAX)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_long     (id_long),
        .id_flush    (id_flush),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .stall       (stall),
        .busy        (busy),
        .outstanding (outstanding),
        .idle        (idle),
        .err         (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(pend[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    function automatic bit m_retire();
        return wb_valid && (wb_rd != 5'd0) && pend[int'(wb_rd)];
    endfunction

    function automatic bit m_eff(input int r);
        return pend[r] && !(m_retire() && int'(wb_rd) == r);
    endfunction

    function automatic bit m_stall();
        bit hraw, hwaw, hfull;
        hraw  = (id_use_rs1 && m_eff(int'(id_rs1))) || (id_use_rs2 && m_eff(int'(id_rs2)));
        hwaw  = id_reg_write && m_eff(int'(id_rd));
        hfull = id_long && id_reg_write && (m_count() == int'(MAX)) && !m_retire();
        return id_valid && !id_flush && (hraw || hwaw || hfull);
    endfunction

    task automatic clr_in();
        id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
        id_long = 0; id_flush = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_valid = 0; wb_rd = 0;
    endtask

    task automatic issue(input int rd);
        clr_in();
        id_valid = 1; id_reg_write = 1; id_long = 1; id_rd = 5'(rd);
    endtask

    task automatic retire_only(input int rd);
        clr_in();
        wb_valid = 1; wb_rd = 5'(rd);
    endtask

    // One cycle: starts at posedge+1 with inputs driven; es<0 means no directed stall value
    task automatic step(input int es);
        bit ms, ret, acc;
        #1;
        ms = m_stall();
        check("stall", stall, ms);
        if (es >= 0) check("stall_dir", stall, 32'(es));
        ret = m_retire();
        acc = id_valid && !id_flush && !ms;
        if (ret) pend[int'(wb_rd)] = 0;
        if (acc && id_reg_write && id_long && id_rd != 5'd0) pend[int'(id_rd)] = 1;
        if (wb_valid && !ret) m_err = 1;
        @(posedge clk);
        #1;
        check("busy", busy, m_busy());
        check("outstanding", outstanding, m_count());
        check("idle", idle, m_count() == 0);
        check("err", err, m_err);
    endtask

    task automatic async_reset();
        #3;
        rst_n = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err, 0);
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        clr_in();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_outstanding", outstanding, 0);
        check("reset_idle", idle, 1);
        check("reset_err", err, 0);
        rst_n = 1;

        // Load-use RAW
        issue(5);
        step(0);
        clr_in(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5;
        repeat (3) step(1);
        wb_valid = 1; wb_rd = 5;
        step(0);
        check("raw_busy5", busy[5], 0);
        check("raw_outstanding", outstanding, 0);

        // WAW with same-cycle retire: issue set wins
        issue(7);
        step(0);
        issue(7); wb_valid = 1; wb_rd = 7;
        step(0);
        check("waw_busy7", busy[7], 1);
        check("waw_outstanding", outstanding, 1);
        retire_only(7);
        step(-1);

        // Full
        for (int r = 1; r <= 4; r++) begin
            issue(r);
            step(0);
        end
        issue(9);
        step(1);
        check("full_outstanding", outstanding, 4);
        issue(9); wb_valid = 1; wb_rd = 1;
        step(0);
        check("full_ret_outstanding", outstanding, 4);
        check("full_busy9", busy[9], 1);
        check("full_busy1", busy[1], 0);
        for (int r = 2; r <= 4; r++) begin
            retire_only(r);
            step(-1);
        end
        retire_only(9);
        step(-1);

        // x0 destination and unused source
        issue(0);
        step(0);
        check("x0_busy", busy, 0);
        check("x0_outstanding", outstanding, 0);
        issue(5);
        step(0);
        clr_in(); id_valid = 1; id_rs2 = 5; id_use_rs2 = 0;
        step(0);

        // Flush hides the hazard and changes nothing
        clr_in(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_flush = 1;
        step(0);
        check("flush_busy", busy, 32'h20);
        check("flush_outstanding", outstanding, 1);
        retire_only(5);
        step(-1);

        // Spurious writeback sets sticky err
        retire_only(12);
        step(-1);
        check("err_set", err, 1);
        clr_in();
        repeat (3) step(-1);
        check("err_held", err, 1);

        // Async reset with three pending
        for (int r = 1; r <= 3; r++) begin
            issue(r);
            step(0);
        end
        check("pre_rst_outstanding", outstanding, 3);
        clr_in();
        async_reset();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset();
            clr_in();
            id_valid     = ($urandom_range(0, 3) != 0);
            id_rs1       = 5'($urandom_range(0, 7));
            id_rs2       = 5'($urandom_range(0, 7));
            id_use_rs1   = 1'($urandom_range(0, 1));
            id_use_rs2   = 1'($urandom_range(0, 1));
            id_rd        = 5'($urandom_range(0, 7));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_long      = ($urandom_range(0, 3) != 0);
            id_flush     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 63) == 0) begin
                wb_valid = 1;
                wb_rd    = 5'($urandom_range(0, 31));
            end else if (m_count() > 0 && $urandom_range(0, 2) == 0) begin
                int k;
                k = $urandom_range(0, m_count() - 1);
                wb_valid = 1;
                for (int i = 0; i < 32; i++) begin
                    if (pend[i]) begin
                        if (k == 0) wb_rd = 5'(i);
                        k--;
                    end
                end
            end
            step(-1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
